// File: rtl/flit_inject.sv
// flit_inject: packetizer that turns one message into a head flit plus payload flits under credit flow control.
// Build option FLIT_INJECT_CHECKSUM_EN appends an XOR checksum flit after the payload.
module flit_inject #(
  parameter int BUF_DEPTH = 4,
  parameter int MAX_LEN   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 msg_valid,
  output logic                 msg_ready,
  input  logic [2:0]           msg_dst,
  input  logic [2:0]           msg_len,
  input  logic [8*MAX_LEN-1:0] msg_data,
  output logic [7:0]           o_flit,
  output logic                 Write,
  input  logic                 Read,
  output logic [3:0]           credits
);

  // state | meaning
  // IDLE  | no message held, msg_ready high
  // HEAD  | message latched, head flit waiting for a credit
  // BODY  | payload bytes still to send
  // CSUM  | checksum flit waiting for a credit (checksum build only)
`ifdef FLIT_INJECT_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, HEAD, BODY, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;
`endif

  localparam logic [3:0] DEPTH = 4'(BUF_DEPTH);
  localparam logic [2:0] MAXL  = 3'(MAX_LEN);

  state_t               state;
  logic [2:0]           dst_q;
  logic [2:0]           len_q;
  logic [2:0]           idx;
  logic [8*MAX_LEN-1:0] data_q;
`ifdef FLIT_INJECT_CHECKSUM_EN
  logic [7:0]           csum_q;
`endif

  logic [2:0] eff_len;
  logic       emit;
  logic       give;

  assign eff_len = (msg_len > MAXL) ? MAXL : msg_len;
  assign emit    = (state != IDLE) && (credits != 4'd0);
  // A returned credit on a full counter is dropped unless a flit leaves on the same edge.
  assign give    = Read && (emit || (credits != DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      msg_ready <= 1'b1;
      Write     <= 1'b0;
      o_flit    <= 8'h00;
      credits   <= DEPTH;
      dst_q     <= 3'd0;
      len_q     <= 3'd0;
      idx       <= 3'd0;
      data_q    <= '0;
`ifdef FLIT_INJECT_CHECKSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      Write <= emit;
      if (emit && !give)
        credits <= credits - 4'd1;
      else if (give && !emit)
        credits <= credits + 4'd1;

      case (state)
        IDLE: begin
          if (msg_valid && msg_ready) begin
            dst_q     <= msg_dst;
            len_q     <= eff_len;
            data_q    <= msg_data;
            idx       <= 3'd0;
`ifdef FLIT_INJECT_CHECKSUM_EN
            csum_q    <= 8'h00;
`endif
            msg_ready <= 1'b0;
            state     <= HEAD;
          end
        end
        HEAD: begin
          if (emit) begin
            o_flit <= {2'b01, len_q, dst_q};
            if (len_q == 3'd0) begin
`ifdef FLIT_INJECT_CHECKSUM_EN
              state     <= CSUM;
`else
              state     <= IDLE;
              msg_ready <= 1'b1;
`endif
            end else begin
              state <= BODY;
            end
          end
        end
        BODY: begin
          if (emit) begin
            // data_q shifts down so the next byte is always in the low lane
            o_flit <= data_q[7:0];
            data_q <= data_q >> 8;
            idx    <= idx + 3'd1;
`ifdef FLIT_INJECT_CHECKSUM_EN
            csum_q <= csum_q ^ data_q[7:0];
`endif
            if (idx == len_q - 3'd1) begin
`ifdef FLIT_INJECT_CHECKSUM_EN
              state     <= CSUM;
`else
              state     <= IDLE;
              msg_ready <= 1'b1;
`endif
            end
          end
        end
`ifdef FLIT_INJECT_CHECKSUM_EN
        CSUM: begin
          if (emit) begin
            o_flit    <= csum_q;
            state     <= IDLE;
            msg_ready <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
